// File: rtl/wb_pkg.sv
// Shared types for the write-back arbiter: FIFO entry layout and register-file constants.
package wb_pkg;

    localparam int DATA_W = 32;
    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [4:0]        rd;
        logic              to_int;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO of FPU write-back entries; the head is read straight from the array.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  wb_entry_t                push_data,
    input  logic                     pop,
    output wb_entry_t                head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    wb_entry_t         mem [DEPTH];
    logic [AW-1:0]     wr_ptr_reg;
    logic [AW-1:0]     rd_ptr_reg;
    logic [CW-1:0]     count_reg;
    logic              do_push;
    logic              do_pop;

    assign full    = (count_reg == CW'(DEPTH));
    assign empty   = (count_reg == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr_reg];
    assign count   = count_reg;

    // Storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/writeback_arbiter.sv
// Register-file write port: integer results take priority over buffered FPU results,
// with a starvation release and a pending-destination scoreboard for decode.
module writeback_arbiter
    import wb_pkg::*;
#(
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4,
    parameter int XLEN         = DATA_W
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        int_valid,
    input  logic [4:0]                  int_rd,
    input  logic                        int_fpu,
    input  logic [XLEN-1:0]             int_result,
    output logic                        int_ready,
    input  logic                        fpu_valid,
    input  logic [4:0]                  fpu_rd,
    input  logic                        fpu_int,
    input  logic [XLEN-1:0]             fpu_result,
    output logic                        fpu_ready,
    input  logic                        iss_valid,
    input  logic [4:0]                  iss_rd,
    input  logic                        iss_int,
    input  logic [4:0]                  q_rs1,
    input  logic [4:0]                  q_rs2,
    input  logic                        q_fpu1,
    input  logic                        q_fpu2,
    output logic                        busy1,
    output logic                        busy2,
    output logic [4:0]                  rd_w,
    output logic [XLEN-1:0]             result_w,
    output logic                        reg_write_w,
    output logic                        fpu_reg_write_w,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic              alive_reg;
    logic [SW-1:0]     starve_cnt_reg;
    logic [SW-1:0]     starve_cnt_next;
    logic [31:0]       pend_int_reg;
    logic [31:0]       pend_fpu_reg;
    logic [31:0]       pend_int_next;
    logic [31:0]       pend_fpu_next;
    logic [31:0]       set_int, set_fpu, clr_int, clr_fpu;
    logic [4:0]        rd_w_reg;
    logic [XLEN-1:0]   result_w_reg;
    logic              reg_write_w_reg;
    logic              fpu_reg_write_w_reg;

    wb_entry_t         fifo_in;
    wb_entry_t         fifo_head;
    logic              fifo_full;
    logic              fifo_empty;
    logic              starve;
    logic              int_win;
    logic              pop;
    logic              push;

    assign starve    = (starve_cnt_reg == SW'(STARVE_LIMIT));
    assign int_ready = !starve;
    // alive_reg keeps the FIFO closed until the first edge after reset release.
    assign fpu_ready = alive_reg && !fifo_full;
    assign int_win   = int_valid && int_ready;
    assign pop       = !int_win && !fifo_empty;
    assign push      = fpu_valid && fpu_ready;
    assign fifo_in   = '{rd: fpu_rd, to_int: fpu_int, data: fpu_result};

    wb_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (fifo_in),
        .pop       (pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_comb begin
        starve_cnt_next = starve_cnt_reg;
        if (pop || !fifo_full) begin
            starve_cnt_next = '0;
        end else if (int_win) begin
            starve_cnt_next = starve_cnt_reg + SW'(1);
        end
    end

    for (genvar gi = 0; gi < 32; gi++) begin : g_sb
        assign set_int[gi] = iss_valid && iss_int && (iss_rd == 5'(gi)) && (5'(gi) != REG_ZERO);
        assign set_fpu[gi] = iss_valid && !iss_int && (iss_rd == 5'(gi));
        assign clr_int[gi] = pop && fifo_head.to_int && (fifo_head.rd == 5'(gi));
        assign clr_fpu[gi] = pop && !fifo_head.to_int && (fifo_head.rd == 5'(gi));
    end

    // An issue landing on the same bit as a retiring pop leaves the bit set.
    assign pend_int_next = (pend_int_reg & ~clr_int) | set_int;
    assign pend_fpu_next = (pend_fpu_reg & ~clr_fpu) | set_fpu;

    assign busy1 = q_fpu1 ? pend_fpu_reg[q_rs1] : pend_int_reg[q_rs1];
    assign busy2 = q_fpu2 ? pend_fpu_reg[q_rs2] : pend_int_reg[q_rs2];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alive_reg           <= 1'b0;
            starve_cnt_reg      <= '0;
            pend_int_reg        <= '0;
            pend_fpu_reg        <= '0;
            rd_w_reg            <= '0;
            result_w_reg        <= '0;
            reg_write_w_reg     <= 1'b0;
            fpu_reg_write_w_reg <= 1'b0;
        end else begin
            alive_reg      <= 1'b1;
            starve_cnt_reg <= starve_cnt_next;
            pend_int_reg   <= pend_int_next;
            pend_fpu_reg   <= pend_fpu_next;
            if (int_win) begin
                rd_w_reg            <= int_rd;
                result_w_reg        <= int_result;
                reg_write_w_reg     <= !int_fpu && (int_rd != REG_ZERO);
                fpu_reg_write_w_reg <= int_fpu;
            end else if (pop) begin
                rd_w_reg            <= fifo_head.rd;
                result_w_reg        <= fifo_head.data;
                reg_write_w_reg     <= fifo_head.to_int && (fifo_head.rd != REG_ZERO);
                fpu_reg_write_w_reg <= !fifo_head.to_int;
            end else begin
                reg_write_w_reg     <= 1'b0;
                fpu_reg_write_w_reg <= 1'b0;
            end
        end
    end

    assign rd_w            = rd_w_reg;
    assign result_w        = result_w_reg;
    assign reg_write_w     = reg_write_w_reg;
    assign fpu_reg_write_w = fpu_reg_write_w_reg;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Self-checking bench for writeback_arbiter: directed vector table, hand sequences, random traffic vs model.
module tb_writeback_arbiter;

    localparam int DEPTH = 2;
    localparam int LIMIT = 4;

    logic        clk;
    logic        rst;
    logic        int_valid, int_fpu, int_ready;
    logic [4:0]  int_rd;
    logic [31:0] int_result;
    logic        fpu_valid, fpu_int, fpu_ready;
    logic [4:0]  fpu_rd;
    logic [31:0] fpu_result;
    logic        iss_valid, iss_int;
    logic [4:0]  iss_rd;
    logic [4:0]  q_rs1, q_rs2;
    logic        q_fpu1, q_fpu2, busy1, busy2;
    logic [4:0]  rd_w;
    logic [31:0] result_w;
    logic        reg_write_w, fpu_reg_write_w;
    logic [1:0]  fifo_count;

    writeback_arbiter #(
        .FIFO_DEPTH   (DEPTH),
        .STARVE_LIMIT (LIMIT),
        .XLEN         (32)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .int_valid       (int_valid),
        .int_rd          (int_rd),
        .int_fpu         (int_fpu),
        .int_result      (int_result),
        .int_ready       (int_ready),
        .fpu_valid       (fpu_valid),
        .fpu_rd          (fpu_rd),
        .fpu_int         (fpu_int),
        .fpu_result      (fpu_result),
        .fpu_ready       (fpu_ready),
        .iss_valid       (iss_valid),
        .iss_rd          (iss_rd),
        .iss_int         (iss_int),
        .q_rs1           (q_rs1),
        .q_rs2           (q_rs2),
        .q_fpu1          (q_fpu1),
        .q_fpu2          (q_fpu2),
        .busy1           (busy1),
        .busy2           (busy2),
        .rd_w            (rd_w),
        .result_w        (result_w),
        .reg_write_w     (reg_write_w),
        .fpu_reg_write_w (fpu_reg_write_w),
        .fifo_count      (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One cycle of stimulus plus what should be seen before and after the edge.
    typedef struct {
        logic [31:0] iv, ird, ifpu, idata;
        logic [31:0] fv, frd, fint, fdata;
        logic [31:0] sv, srd, sint;
        logic [31:0] rs1, f1, rs2, f2;
        logic [31:0] xir, xfr, xb1, xb2;
        logic [31:0] xrd, xres, xwe, xfwe, xcnt;
    } vec_t;

    typedef struct {
        logic [4:0]  rd;
        logic        to_int;
        logic [31:0] d;
    } ment_t;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model state
    ment_t       mq[$];
    bit          mpi[32];
    bit          mpf[32];
    int          mstarve;
    bit          malive;
    logic [4:0]  m_rd;
    logic [31:0] m_res;
    logic        m_we, m_fwe;

    logic        last_iready, last_fready;
    vec_t        tbl[16];
    vec_t        idle;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        mq.delete();
        for (int i = 0; i < 32; i++) begin
            mpi[i] = 1'b0;
            mpf[i] = 1'b0;
        end
        mstarve = 0;
        malive  = 1'b0;
        m_rd    = '0;
        m_res   = '0;
        m_we    = 1'b0;
        m_fwe   = 1'b0;
    endfunction

    function automatic void model_pre(input vec_t v, output logic ir, output logic fr,
                                      output logic b1, output logic b2);
        fr = malive && (mq.size() < DEPTH);
        ir = (mstarve != LIMIT);
        b1 = v.f1[0] ? mpf[v.rs1[4:0]] : mpi[v.rs1[4:0]];
        b2 = v.f2[0] ? mpf[v.rs2[4:0]] : mpi[v.rs2[4:0]];
    endfunction

    function automatic void model_clk(input vec_t v);
        bit    full, fr, ir, iw, pop, push;
        ment_t h, n;
        full = (mq.size() == DEPTH);
        fr   = malive && !full;
        ir   = (mstarve != LIMIT);
        iw   = v.iv[0] && ir;
        pop  = !iw && (mq.size() > 0);
        push = v.fv[0] && fr;
        if (iw) begin
            m_rd  = v.ird[4:0];
            m_res = v.idata;
            m_we  = !v.ifpu[0] && (v.ird[4:0] != 5'd0);
            m_fwe = v.ifpu[0];
        end else if (pop) begin
            h = mq.pop_front();
            m_rd  = h.rd;
            m_res = h.d;
            m_we  = h.to_int && (h.rd != 5'd0);
            m_fwe = !h.to_int;
            if (h.to_int) mpi[h.rd] = 1'b0;
            else          mpf[h.rd] = 1'b0;
        end else begin
            m_we  = 1'b0;
            m_fwe = 1'b0;
        end
        if (pop || !full) mstarve = 0;
        else if (iw)      mstarve = mstarve + 1;
        if (v.sv[0]) begin
            if (v.sint[0]) begin
                if (v.srd[4:0] != 5'd0) mpi[v.srd[4:0]] = 1'b1;
            end else begin
                mpf[v.srd[4:0]] = 1'b1;
            end
        end
        if (push) begin
            n.rd = v.frd[4:0];
            n.to_int = v.fint[0];
            n.d = v.fdata;
            mq.push_back(n);
        end
        malive = 1'b1;
    endfunction

    task automatic drive(input vec_t v);
        int_valid  = v.iv[0];
        int_rd     = v.ird[4:0];
        int_fpu    = v.ifpu[0];
        int_result = v.idata;
        fpu_valid  = v.fv[0];
        fpu_rd     = v.frd[4:0];
        fpu_int    = v.fint[0];
        fpu_result = v.fdata;
        iss_valid  = v.sv[0];
        iss_rd     = v.srd[4:0];
        iss_int    = v.sint[0];
        q_rs1      = v.rs1[4:0];
        q_fpu1     = v.f1[0];
        q_rs2      = v.rs2[4:0];
        q_fpu2     = v.f2[0];
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic step(input string tag, input int idx, input vec_t v, input bit use_model);
        vec_t e;
        logic mir, mfr, mb1, mb2;
        e = v;
        drive(v);
        #1;
        model_pre(v, mir, mfr, mb1, mb2);
        if (use_model) begin
            e.xir = 32'(mir);
            e.xfr = 32'(mfr);
            e.xb1 = 32'(mb1);
            e.xb2 = 32'(mb2);
        end
        last_iready = int_ready;
        last_fready = fpu_ready;
        chk($sformatf("%s%0d int_ready", tag, idx), 32'(int_ready), e.xir);
        chk($sformatf("%s%0d fpu_ready", tag, idx), 32'(fpu_ready), e.xfr);
        chk($sformatf("%s%0d busy1", tag, idx), 32'(busy1), e.xb1);
        chk($sformatf("%s%0d busy2", tag, idx), 32'(busy2), e.xb2);
        @(posedge clk);
        model_clk(v);
        #1;
        if (use_model) begin
            e.xrd  = 32'(m_rd);
            e.xres = m_res;
            e.xwe  = 32'(m_we);
            e.xfwe = 32'(m_fwe);
            e.xcnt = 32'(mq.size());
        end
        chk($sformatf("%s%0d rd_w", tag, idx), 32'(rd_w), e.xrd);
        chk($sformatf("%s%0d result_w", tag, idx), result_w, e.xres);
        chk($sformatf("%s%0d reg_write_w", tag, idx), 32'(reg_write_w), e.xwe);
        chk($sformatf("%s%0d fpu_reg_write_w", tag, idx), 32'(fpu_reg_write_w), e.xfwe);
        chk($sformatf("%s%0d fifo_count", tag, idx), 32'(fifo_count), e.xcnt);
        $display("[TB] %s%0d int=%0d/%0d fpu=%0d/%0d iss=%0d/%0d -> rd_w=%0d result_w=%h we=%0d fwe=%0d cnt=%0d",
                 tag, idx, v.iv[0], v.ird[4:0], v.fv[0], v.frd[4:0], v.sv[0], v.srd[4:0],
                 rd_w, result_w, reg_write_w, fpu_reg_write_w, fifo_count);
        @(negedge clk);
    endtask

    function automatic vec_t rnd_vec();
        vec_t v;
        v = '{default: 0};
        v.iv    = ($urandom_range(0, 99) < 45) ? 1 : 0;
        v.ird   = $urandom_range(0, 7);
        v.ifpu  = $urandom_range(0, 1);
        v.idata = $urandom;
        v.fv    = ($urandom_range(0, 99) < 50) ? 1 : 0;
        v.frd   = $urandom_range(0, 7);
        v.fint  = $urandom_range(0, 1);
        v.fdata = $urandom;
        v.sv    = ($urandom_range(0, 99) < 30) ? 1 : 0;
        v.srd   = $urandom_range(0, 7);
        v.sint  = $urandom_range(0, 1);
        v.rs1   = $urandom_range(0, 7);
        v.f1    = $urandom_range(0, 1);
        v.rs2   = $urandom_range(0, 7);
        v.f2    = $urandom_range(0, 1);
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        idle = '{default: 0};
        //        iv ird ifpu idata           fv frd fint fdata          sv srd sint rs1 f1 rs2 f2  ir fr b1 b2  rd  res            we fwe cnt
        tbl[0]  = '{1, 5, 0, 32'hDEADBEEF,   0, 0, 0, 0,              0, 0, 0,   0, 0, 0, 0,   1, 1, 0, 0,   5, 32'hDEADBEEF, 1, 0, 0};
        tbl[1]  = '{1, 0, 0, 32'h11111111,   0, 0, 0, 0,              0, 0, 0,   0, 0, 0, 0,   1, 1, 0, 0,   0, 32'h11111111, 0, 0, 0};
        tbl[2]  = '{1, 0, 1, 32'h22222222,   0, 0, 0, 0,              0, 0, 0,   0, 0, 0, 0,   1, 1, 0, 0,   0, 32'h22222222, 0, 1, 0};
        tbl[3]  = '{0, 0, 0, 0,              0, 0, 0, 0,              0, 0, 0,   0, 0, 0, 0,   1, 1, 0, 0,   0, 32'h22222222, 0, 0, 0};
        tbl[4]  = '{0, 0, 0, 0,              0, 0, 0, 0,              1, 3, 0,   3, 1, 3, 0,   1, 1, 0, 0,   0, 32'h22222222, 0, 0, 0};
        tbl[5]  = '{0, 0, 0, 0,              1, 3, 0, 32'h3F800000,   0, 0, 0,   3, 1, 3, 0,   1, 1, 1, 0,   0, 32'h22222222, 0, 0, 1};
        tbl[6]  = '{0, 0, 0, 0,              0, 0, 0, 0,              0, 0, 0,   3, 1, 3, 0,   1, 1, 1, 0,   3, 32'h3F800000, 0, 1, 0};
        tbl[7]  = '{0, 0, 0, 0,              0, 0, 0, 0,              0, 0, 0,   3, 1, 3, 0,   1, 1, 0, 0,   3, 32'h3F800000, 0, 0, 0};
        tbl[8]  = '{0, 0, 0, 0,              1, 7, 0, 32'hA5A5A5A5,   0, 0, 0,   7, 1, 0, 0,   1, 1, 0, 0,   3, 32'h3F800000, 0, 0, 1};
        tbl[9]  = '{0, 0, 0, 0,              0, 0, 0, 0,              1, 7, 0,   7, 1, 0, 0,   1, 1, 0, 0,   7, 32'hA5A5A5A5, 0, 1, 0};
        tbl[10] = '{0, 0, 0, 0,              0, 0, 0, 0,              1, 0, 1,   7, 1, 0, 0,   1, 1, 1, 0,   7, 32'hA5A5A5A5, 0, 0, 0};
        tbl[11] = '{0, 0, 0, 0,              1, 9, 1, 32'h12345678,   0, 0, 0,   7, 1, 0, 0,   1, 1, 1, 0,   7, 32'hA5A5A5A5, 0, 0, 1};
        tbl[12] = '{0, 0, 0, 0,              0, 0, 0, 0,              0, 0, 0,   0, 0, 0, 0,   1, 1, 0, 0,   9, 32'h12345678, 1, 0, 0};
        tbl[13] = '{1, 0, 1, 32'hCAFEF00D,   0, 0, 0, 0,              0, 0, 0,   0, 0, 0, 0,   1, 1, 0, 0,   0, 32'hCAFEF00D, 0, 1, 0};
        tbl[14] = '{1, 31, 0, 32'h00000001,  1, 2, 0, 32'h00000005,   0, 0, 0,   0, 0, 0, 0,   1, 1, 0, 0,  31, 32'h00000001, 1, 0, 1};
        tbl[15] = '{0, 0, 0, 0,              0, 0, 0, 0,              0, 0, 0,   0, 0, 0, 0,   1, 1, 0, 0,   2, 32'h00000005, 0, 1, 0};

        rst = 1'b0;
        drive(idle);
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        step("init", 0, idle, 1'b1);

        for (int i = 0; i < 16; i++) begin
            step("vec", i, tbl[i], 1'b0);
        end

        // Fill the FIFO behind integer traffic, then reset mid-operation.
        v = idle;
        v.iv = 1; v.ird = 6; v.idata = 32'h66;
        v.fv = 1; v.frd = 4; v.fdata = 32'h44;
        v.sv = 1; v.srd = 4;
        step("fill", 0, v, 1'b1);
        v = idle;
        v.iv = 1; v.ird = 8; v.idata = 32'h88;
        v.fv = 1; v.frd = 5; v.fdata = 32'h55;
        step("fill", 1, v, 1'b1);
        v = idle;
        v.rs1 = 4; v.f1 = 1; v.rs2 = 7; v.f2 = 1;
        drive(v);
        #1;
        chk("pre_reset busy1", 32'(busy1), 32'd1);
        chk("pre_reset busy2", 32'(busy2), 32'd1);
        chk("pre_reset fifo_count", 32'(fifo_count), 32'd2);
        #1 rst = 1'b0;
        #1;
        chk("reset rd_w", 32'(rd_w), 32'd0);
        chk("reset result_w", result_w, 32'd0);
        chk("reset reg_write_w", 32'(reg_write_w), 32'd0);
        chk("reset fpu_reg_write_w", 32'(fpu_reg_write_w), 32'd0);
        chk("reset fifo_count", 32'(fifo_count), 32'd0);
        chk("reset busy1", 32'(busy1), 32'd0);
        chk("reset busy2", 32'(busy2), 32'd0);
        chk("reset fpu_ready", 32'(fpu_ready), 32'd0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        step("release", 0, v, 1'b1);
        chk("release fpu_ready", 32'(fpu_ready), 32'd1);

        // Starvation: full FIFO with integer results offered every cycle.
        v = idle;
        v.iv = 1; v.ird = 1; v.idata = 32'h100;
        v.fv = 1; v.frd = 10; v.fdata = 32'hAAAA0010;
        step("starve_fill", 0, v, 1'b1);
        v.idata = 32'h101; v.frd = 11; v.fdata = 32'hAAAA0011;
        step("starve_fill", 1, v, 1'b1);
        v = idle;
        v.iv = 1; v.ird = 1;
        for (int k = 0; k < LIMIT; k++) begin
            v.idata = 32'h200 + k;
            step("starve", k, v, 1'b1);
            chk($sformatf("starve%0d int_ready high", k), 32'(last_iready), 32'd1);
            chk($sformatf("starve%0d fpu_ready low", k), 32'(last_fready), 32'd0);
        end
        v.idata = 32'h2FF;
        step("starve", LIMIT, v, 1'b1);
        chk("starve release int_ready", 32'(last_iready), 32'd0);
        chk("starve release rd_w", 32'(rd_w), 32'd10);
        chk("starve release result_w", result_w, 32'hAAAA0010);
        chk("starve release fpu_reg_write_w", 32'(fpu_reg_write_w), 32'd1);
        chk("starve after fpu_ready", 32'(fpu_ready), 32'd1);
        chk("starve after int_ready", 32'(int_ready), 32'd1);

        for (int i = 0; i < 600; i++) begin
            step("rnd", i, rnd_vec(), 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
